// File: rtl/env_code_encoder_if.sv
// Handshake and result bundle for env_code_encoder.
// slave: the encoder side; master: the producer/consumer driving it.
interface env_code_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic [3:0]  param;
  logic        underflow;

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_byte, out_last, param, underflow
  );

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_byte, out_last, param, underflow
  );
endinterface

// File: rtl/env_code_encoder.sv
// Linear 19-bit envelope value -> {shift param, 13-bit mantissa (implied one)}.
// The mantissa is emitted as two ROM bytes, low byte first.
// Optional rounding in PACK: define ENV_ENC_ROUND_EN (default: truncation, no adder).
module env_code_encoder #(
  parameter int SCAN_INIT = 11
) (
  input  logic            clk,
  input  logic            rst,
  env_code_encoder_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_PACK  = 3'd2;
  localparam logic [2:0] S_SEND0 = 3'd3;
  localparam logic [2:0] S_SEND1 = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [18:0] w_q, w_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [12:0] m_q, m_d;
  logic [3:0]  p_q, p_d;
  logic        uf_q, uf_d;
`ifdef ENV_ENC_ROUND_EN
  logic [13:0] m_rnd;
`endif

  // Outputs decode straight from state so nothing moves while a byte is held.
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_SEND0) || (state_q == S_SEND1);
    bus.out_last  = (state_q == S_SEND1);
    bus.out_byte  = 8'h00;
    if (state_q == S_SEND0) bus.out_byte = m_q[7:0];
    if (state_q == S_SEND1) bus.out_byte = {3'b000, m_q[12:8]};
    bus.param     = p_q;
    bus.underflow = uf_q;
  end

  // Next-state: normalise by left shifts, one decision per cycle.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    p_d     = p_q;
    uf_d    = uf_q;
`ifdef ENV_ENC_ROUND_EN
    m_rnd   = {1'b0, w_q[17:5]} + {13'd0, w_q[4]};
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_d     = bus.in_value;
          cnt_d   = SCAN_INIT[3:0];
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_q[18]) begin
          p_d     = cnt_q;
          state_d = S_PACK;
        end else if (cnt_q == 4'd0) begin
          // Below 128: no representable leading one; decodes to zero.
          uf_d    = 1'b1;
          p_d     = 4'd12;
          m_d     = 13'd0;
          state_d = S_SEND0;
        end else begin
          w_d   = {w_q[17:0], 1'b0};
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_PACK: begin
`ifdef ENV_ENC_ROUND_EN
        if (m_rnd[13]) begin
          // Carry out of the mantissa bumps the exponent; top exponent saturates.
          if (p_q == 4'd11) begin
            m_d = 13'h1FFF;
          end else begin
            m_d = 13'd0;
            p_d = p_q + 4'd1;
          end
        end else begin
          m_d = m_rnd[12:0];
        end
`else
        m_d = w_q[17:5];
`endif
        state_d = S_SEND0;
      end
      S_SEND0: begin
        if (bus.out_ready) state_d = S_SEND1;
      end
      S_SEND1: begin
        if (bus.out_ready) begin
          uf_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; async reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      m_q     <= '0;
      p_q     <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      p_q     <= p_d;
      uf_q    <= uf_d;
    end
  end

endmodule
